// File: rtl/fpa_pkg.sv
// Shared types and constants for the FP array-reduction feeder.
package fpa_pkg;

    // Feeder sequencing: collect operands, clear the adder, run it, hand back the result.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } feeder_state_t;

    // Bit positions inside the {EXC,UNF,OVF} result flag field.
    localparam int FLAG_OVF = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_EXC = 2;

    // Operation codes understood by the array adder.
    localparam logic [1:0] FPA_OPER_ADD     = 2'd0;
    localparam logic [1:0] FPA_OPER_SUB     = 2'd1;
    localparam logic [1:0] FPA_OPER_ABS_ADD = 2'd2;
    localparam logic [1:0] FPA_OPER_RSVD    = 2'd3;

endpackage

// File: rtl/fpa_arr_feeder_if.sv
// Operand stream, adder and result signals of the FP array feeder.
//
// Handshakes: a word on the S port moves on a rising edge where iS_VALID and
// oS_READY are both high; a result on the R port moves on a rising edge where
// oR_VALID and iR_READY are both high. A valid side never withdraws its payload
// before the transfer, and its data stays stable while valid is high.
interface fpa_arr_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16
);
    import fpa_pkg::*;

    logic                         iS_VALID;
    logic                         oS_READY;
    logic [DATA_WIDTH-1:0]        iS_DATA;
    logic [1:0]                   iS_OPER;

    logic                         oADD_NRESET;
    logic                         oADD_EN;
    logic [N:0][DATA_WIDTH-1:0]   oADD_NUMBERS;
    logic [1:0]                   oADD_OPERATION;
    logic [DATA_WIDTH-1:0]        iADD_RESULT;
    logic                         iADD_DATA_VALID;
    logic                         iADD_OVERFLOW;
    logic                         iADD_UNDERFLOW;
    logic                         iADD_EXCEPTION;

    logic                         oR_VALID;
    logic                         iR_READY;
    logic [DATA_WIDTH-1:0]        oR_DATA;
    logic [2:0]                   oR_FLAGS;
    logic                         oR_TIMEOUT;

    // Current sequencer state, exported for observation.
    feeder_state_t                dbg_state;

    modport master (
        input  iS_VALID, iS_DATA, iS_OPER,
        input  iADD_RESULT, iADD_DATA_VALID, iADD_OVERFLOW, iADD_UNDERFLOW, iADD_EXCEPTION,
        input  iR_READY,
        output oS_READY,
        output oADD_NRESET, oADD_EN, oADD_NUMBERS, oADD_OPERATION,
        output oR_VALID, oR_DATA, oR_FLAGS, oR_TIMEOUT,
        output dbg_state
    );

    modport slave (
        output iS_VALID, iS_DATA, iS_OPER,
        output iADD_RESULT, iADD_DATA_VALID, iADD_OVERFLOW, iADD_UNDERFLOW, iADD_EXCEPTION,
        output iR_READY,
        input  oS_READY,
        input  oADD_NRESET, oADD_EN, oADD_NUMBERS, oADD_OPERATION,
        input  oR_VALID, oR_DATA, oR_FLAGS, oR_TIMEOUT,
        input  dbg_state
    );

endinterface

// File: rtl/fpa_word_buffer.sv
// Operand buffer: N+1 words, one indexed write per cycle, cleared by reset.
module fpa_word_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16,
    parameter int IDX_W      = $clog2(N + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [N:0][DATA_WIDTH-1:0] words
);

    // Store the incoming word at its slot; reset empties every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/fpa_arr_feeder.sv
// Initiator for the FP array adder: gathers N+1 operand words, pulses the
// adder clear, runs the adder under a watchdog and returns result plus flags.
module fpa_arr_feeder
    import fpa_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int N              = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               iCLK,
    input  logic               iNRESET,
    fpa_arr_feeder_if.master   bus
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

    feeder_state_t              state;
    logic [CNT_W-1:0]           count;
    logic [TMR_W-1:0]           timer;
    logic [1:0]                 oper_q;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [2:0]                 r_flags;
    logic                       r_timeout;
    logic                       accept;
    logic [N:0][DATA_WIDTH-1:0] words;

    // A word is taken only while collecting operands.
    assign accept = bus.iS_VALID && (state == LOAD);

    fpa_word_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_W      (CNT_W)
    ) u_buf (
        .clk     (iCLK),
        .rst_n   (iNRESET),
        .wr_en   (accept),
        .wr_idx  (count),
        .wr_data (bus.iS_DATA),
        .words   (words)
    );

    // The adder clear follows our own reset and is also pulsed for one CLR cycle.
    assign bus.oS_READY       = (state == LOAD);
    assign bus.oADD_NRESET    = iNRESET & (state != CLR);
    assign bus.oADD_EN        = (state == RUN);
    assign bus.oADD_NUMBERS   = words;
    assign bus.oADD_OPERATION = oper_q;
    assign bus.oR_VALID       = (state == DONE);
    assign bus.oR_DATA        = r_data;
    assign bus.oR_FLAGS       = r_flags;
    assign bus.oR_TIMEOUT     = r_timeout;
    assign bus.dbg_state      = state;

    // Sequencer with word counter, watchdog timer and result capture.
    always_ff @(posedge iCLK or negedge iNRESET) begin
        if (!iNRESET) begin
            state     <= LOAD;
            count     <= '0;
            timer     <= '0;
            oper_q    <= '0;
            r_data    <= '0;
            r_flags   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (count == '0) begin
                            oper_q <= bus.iS_OPER;
                        end
                        if (count == LAST_IDX) begin
                            count <= '0;
                            state <= CLR;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                CLR: begin
                    state <= RUN;
                end
                RUN: begin
                    timer <= timer + 1'b1;
                    // A result arriving on the last allowed cycle still counts.
                    if (bus.iADD_DATA_VALID) begin
                        r_data             <= bus.iADD_RESULT;
                        r_flags[FLAG_OVF]  <= bus.iADD_OVERFLOW;
                        r_flags[FLAG_UNF]  <= bus.iADD_UNDERFLOW;
                        r_flags[FLAG_EXC]  <= bus.iADD_EXCEPTION;
                        r_timeout          <= 1'b0;
                        state              <= DONE;
                    end else if (timer == LAST_TICK) begin
                        r_data    <= '0;
                        r_flags   <= '0;
                        r_timeout <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.iR_READY) begin
                        timer <= '0;
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_arr_feeder.sv
// Bench for fpa_arr_feeder: directed job table, reset/stray-valid sequences
// and randomized jobs checked against an outcome model.
module tb_fpa_arr_feeder;
    import fpa_pkg::*;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int TO = 64;

    typedef struct {
        int          gap_max;
        logic [1:0]  oper;
        int          lat;          // RUN cycle (1-based) carrying adder valid; 0 = silent
        logic [31:0] result;
        logic [2:0]  flags;        // {EXC,UNF,OVF}
        int          ready_delay;
        bit          ones;         // all operands 1.0
        logic [31:0] exp_data;
        logic [2:0]  exp_flags;
        logic        exp_to;
    } job_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpa_arr_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    fpa_arr_feeder #(
        .DATA_WIDTH     (DW),
        .N              (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iCLK    (clk),
        .iNRESET (rst_n),
        .bus     (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];
    logic [31:0] cur_words [0:N];
    int acc_cnt = 0;
    int clr_cnt = 0;
    int run_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed traffic: accepted words, adder clear cycles, adder enable cycles.
    always @(negedge clk) begin
        if (rst_n && bus.iS_VALID && bus.oS_READY) acc_cnt++;
        if (rst_n && !bus.oADD_NRESET) clr_cnt++;
        if (bus.oADD_EN) run_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [35:0] ref_outcome(input int lat, input logic [31:0] res, input logic [2:0] fl);
        if (lat >= 1 && lat <= TO) return {1'b0, fl, res};
        return {1'b1, 3'b000, 32'h0};
    endfunction

    function automatic int ref_run_cycles(input int lat);
        if (lat >= 1 && lat <= TO) return lat;
        return TO;
    endfunction

    function automatic job_t mk_job(input int gap_max, input logic [1:0] oper, input int lat,
                                    input logic [31:0] result, input logic [2:0] flags,
                                    input int ready_delay, input bit ones,
                                    input logic [31:0] exp_data, input logic [2:0] exp_flags,
                                    input logic exp_to);
        job_t j;
        j.gap_max = gap_max; j.oper = oper; j.lat = lat; j.result = result; j.flags = flags;
        j.ready_delay = ready_delay; j.ones = ones;
        j.exp_data = exp_data; j.exp_flags = exp_flags; j.exp_to = exp_to;
        return j;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.iS_VALID = 1'b0; bus.iS_DATA = '0; bus.iS_OPER = '0;
        bus.iADD_RESULT = '0; bus.iADD_DATA_VALID = 1'b0;
        bus.iADD_OVERFLOW = 1'b0; bus.iADD_UNDERFLOW = 1'b0; bus.iADD_EXCEPTION = 1'b0;
        bus.iR_READY = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},   64'(bus.oS_READY), 64'd1);
        check({tag, "_add_en"},    64'(bus.oADD_EN), 64'd0);
        check({tag, "_add_nrst"},  64'(bus.oADD_NRESET), 64'd0);
        check({tag, "_add_oper"},  64'(bus.oADD_OPERATION), 64'd0);
        check({tag, "_r_valid"},   64'(bus.oR_VALID), 64'd0);
        check({tag, "_r_data"},    64'(bus.oR_DATA), 64'd0);
        check({tag, "_r_flags"},   64'(bus.oR_FLAGS), 64'd0);
        check({tag, "_r_timeout"}, 64'(bus.oR_TIMEOUT), 64'd0);
        for (int i = 0; i <= N; i++) begin
            check($sformatf("%s_numbers%0d", tag, i), 64'(bus.oADD_NUMBERS[i]), 64'd0);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic drive_word(input logic [31:0] d, input logic [1:0] o);
        bit done = 1'b0;
        int guard = 0;
        bus.iS_VALID = 1'b1; bus.iS_DATA = d; bus.iS_OPER = o;
        while (!done && guard < 20) begin
            @(negedge clk);
            done = bus.oS_READY;
            @(posedge clk); #1;
            guard++;
        end
        bus.iS_VALID = 1'b0;
        if (!done) check("word_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_job(input job_t j, input string tag);
        logic [35:0] got;
        logic [35:0] exp;
        int          k;
        bit          seen;
        int          exp_run;
        exp_run = ref_run_cycles(j.lat);
        exp_q.push_back({j.exp_to, j.exp_flags, j.exp_data});
        for (int i = 0; i <= N; i++) cur_words[i] = j.ones ? 32'h3F800000 : $urandom;
        acc_cnt = 0; clr_cnt = 0; run_cnt = 0;

        // load: operand words with random idle gaps; oper is junk after word 0
        for (int i = 0; i <= N; i++) begin
            repeat ($urandom_range(0, j.gap_max)) begin @(posedge clk); #1; end
            drive_word(cur_words[i], (i == 0) ? j.oper : 2'($urandom_range(0, 3)));
        end

        // clear cycle directly after the last accepted word
        @(negedge clk);
        check({tag, "_clr_nrst"},  64'(bus.oADD_NRESET), 64'd0);
        check({tag, "_clr_en"},    64'(bus.oADD_EN), 64'd0);
        check({tag, "_clr_ready"}, 64'(bus.oS_READY), 64'd0);

        // run: the adder answers on RUN cycle j.lat (or never)
        k = 0; seen = 1'b0;
        while (!seen && k < TO + 20) begin
            @(posedge clk); #1;
            k++;
            bus.iADD_DATA_VALID = (j.lat == k);
            bus.iADD_RESULT     = (j.lat == k) ? j.result : $urandom;
            {bus.iADD_EXCEPTION, bus.iADD_UNDERFLOW, bus.iADD_OVERFLOW} =
                (j.lat == k) ? j.flags : 3'($urandom_range(0, 7));
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_run_en"},   64'(bus.oADD_EN), 64'd1);
                check({tag, "_run_oper"}, 64'(bus.oADD_OPERATION), 64'(j.oper));
                for (int i = 0; i <= N; i++) begin
                    check($sformatf("%s_numbers%0d", tag, i), 64'(bus.oADD_NUMBERS[i]), 64'(cur_words[i]));
                end
            end
            seen = bus.oR_VALID;
        end
        bus.iADD_DATA_VALID = 1'b0;
        check({tag, "_result_latency"}, 64'(k), 64'(exp_run + 1));

        got = {bus.oR_TIMEOUT, bus.oR_FLAGS, bus.oR_DATA};
        exp = exp_q.pop_front();
        check({tag, "_result"}, 64'(got), 64'(exp));
        check({tag, "_done_ready"}, 64'(bus.oS_READY), 64'd0);

        // hold: consumer stalls while the source keeps offering a word
        for (int c = 0; c < j.ready_delay; c++) begin
            @(posedge clk); #1;
            bus.iS_VALID = 1'b1; bus.iS_DATA = $urandom;
            @(negedge clk);
            check({tag, "_hold"}, 64'({bus.oR_VALID, bus.oR_TIMEOUT, bus.oR_FLAGS, bus.oR_DATA, bus.oS_READY}),
                  64'({1'b1, got, 1'b0}));
        end
        @(posedge clk); #1;
        bus.iS_VALID = 1'b0;
        bus.iR_READY = 1'b1;
        @(posedge clk); #1;
        bus.iR_READY = 1'b0;
        check({tag, "_accepted"},  64'(acc_cnt), 64'(N + 1));
        check({tag, "_clr_count"}, 64'(clr_cnt), 64'd1);
        check({tag, "_run_count"}, 64'(run_cnt), 64'(exp_run));
        @(negedge clk);
        check({tag, "_ret_valid"}, 64'(bus.oR_VALID), 64'd0);
        check({tag, "_ret_ready"}, 64'(bus.oS_READY), 64'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    job_t tbl[7];
    job_t rj;
    logic [35:0] m;

    initial begin
        tbl[0] = mk_job(0, FPA_OPER_ADD, 10, 32'h41880000, 3'b000, 0, 1, 32'h41880000, 3'b000, 1'b0);
        tbl[1] = mk_job(3, FPA_OPER_SUB, 5,  32'h40000000, 3'b000, 5, 0, 32'h40000000, 3'b000, 1'b0);
        tbl[2] = mk_job(0, FPA_OPER_ADD, 0,  32'h12345678, 3'b111, 1, 0, 32'h0,        3'b000, 1'b1);
        tbl[3] = mk_job(1, FPA_OPER_ABS_ADD, TO, 32'hC0A00000, 3'b010, 0, 0, 32'hC0A00000, 3'b010, 1'b0);
        tbl[4] = mk_job(0, FPA_OPER_ADD, 3,  32'h7F800000, 3'b001, 2, 1, 32'h7F800000, 3'b001, 1'b0);
        tbl[5] = mk_job(0, FPA_OPER_SUB, TO + 1, 32'h3F000000, 3'b100, 0, 0, 32'h0,   3'b000, 1'b1);
        tbl[6] = mk_job(2, FPA_OPER_RSVD, 1, 32'hBF800000, 3'b110, 3, 0, 32'hBF800000, 3'b110, 1'b0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed jobs (normal sum, stalls, timeout, valid on timeout cycle, overflow)
        for (int t = 0; t < 7; t++) begin
            if (t == 4) begin
                // stray adder valid while loading must not produce a result
                for (int c = 0; c < 3; c++) begin
                    bus.iADD_DATA_VALID = 1'b1; bus.iADD_RESULT = 32'hDEADBEEF;
                    @(negedge clk);
                    check("stray_r_valid", 64'(bus.oR_VALID), 64'd0);
                    check("stray_ready",   64'(bus.oS_READY), 64'd1);
                    @(posedge clk); #1;
                end
                bus.iADD_DATA_VALID = 1'b0;
            end
            run_job(tbl[t], $sformatf("tbl%0d", t));
        end

        // reset in the middle of a load discards the partial operand set
        for (int i = 0; i < 8; i++) drive_word($urandom, 2'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midload_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(tbl[0], "after_reset");

        // random jobs against the outcome model
        for (int r = 0; r < 8; r++) begin
            rj.gap_max     = $urandom_range(0, 2);
            rj.oper        = 2'($urandom_range(0, 3));
            rj.lat         = $urandom_range(0, TO + 6);
            rj.result      = $urandom;
            rj.flags       = 3'($urandom_range(0, 7));
            rj.ready_delay = $urandom_range(0, 3);
            rj.ones        = 1'b0;
            m = ref_outcome(rj.lat, rj.result, rj.flags);
            rj.exp_to    = m[35];
            rj.exp_flags = m[34:32];
            rj.exp_data  = m[31:0];
            run_job(rj, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
